// File: rtl/mil_arb_pkg.sv
// Shared definitions for the memory-bus arbiter.
// Contents:
//   arb_state_t  - arbiter FSM states (IDLE, GRANTED, GAP)
//   MAX_CLIENTS  - largest supported requester count
//   MAX_IDX_W    - index width for MAX_CLIENTS
//   rr_pick      - round-robin search over a MAX_CLIENTS-wide request vector,
//                  returns {found, idx}
package mil_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        GAP     = 2'd2
    } arb_state_t;

    localparam int MAX_CLIENTS = 8;
    localparam int MAX_IDX_W   = 3;

    // Search starts at ptr and wraps modulo MAX_CLIENTS. Unused upper request
    // bits are zero, so the wrap behaves like a wrap at the real client count.
    // The loop runs from the farthest offset down so the nearest hit wins.
    function automatic logic [MAX_IDX_W:0] rr_pick(
        input logic [MAX_CLIENTS-1:0] req,
        input logic [MAX_IDX_W-1:0]   ptr
    );
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_IDX_W-1:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = MAX_CLIENTS - 1; k >= 0; k--) begin
            cand  = ptr + 3'(k);
            idx   = req[cand] ? cand : idx;
            found = found | req[cand];
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin winner selection.
// The request vector is rotated so the pointer position lands on bit 0, the
// lowest set bit is priority-encoded, and the index is rotated back.
// Ports:
//   req_i    [N_CLIENTS]  request vector, bit i = client i
//   ptr_i    [IDX]        client with highest priority this round
//   found_o               at least one request is set
//   idx_o    [IDX]        winning client index (valid when found_o=1)
module rr_priority_picker
    import mil_arb_pkg::*;
#(
    parameter int N_CLIENTS = 4
) (
    input  logic [N_CLIENTS-1:0]         req_i,
    input  logic [$clog2(N_CLIENTS)-1:0] ptr_i,
    output logic                         found_o,
    output logic [$clog2(N_CLIENTS)-1:0] idx_o
);
    localparam int IDX_W = $clog2(N_CLIENTS);

    logic [2*N_CLIENTS-1:0] dbl_s;
    logic [N_CLIENTS-1:0]   rot_s;
    logic [MAX_IDX_W:0]     pick_s;
    logic [MAX_IDX_W:0]     sum_s;

    // Rotate, priority-encode from bit 0, then map back to a client index.
    always_comb begin
        dbl_s   = {req_i, req_i};
        rot_s   = N_CLIENTS'(dbl_s >> ptr_i);
        pick_s  = rr_pick(MAX_CLIENTS'(rot_s), 3'd0);
        found_o = pick_s[MAX_IDX_W];
        sum_s   = 4'(pick_s[MAX_IDX_W-1:0]) + 4'(ptr_i);
        idx_o   = (sum_s >= 4'(N_CLIENTS)) ? IDX_W'(sum_s - 4'(N_CLIENTS))
                                           : IDX_W'(sum_s);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory port.
// One registered one-hot grant gates each client's bus drive. A dead gap of
// GAP_CYCLES separates owners; an owner holding for HOLD_LIMIT cycles raises a
// sticky hold_err_o (grant is kept).
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   request_i      [N]   per-client level request
//   grant_o        [N]   one-hot or zero, registered
//   owner_o        [IDX] current holder, valid when busy_o=1
//   busy_o               a grant is asserted
//   hold_err_o           sticky hold-limit overrun flag
//   err_client_o   [IDX] owner that caused the first hold_err_o
//   err_clear_i          synchronous clear of hold_err_o / err_client_o
module mem_bus_arbiter
    import mil_arb_pkg::*;
#(
    parameter int N_CLIENTS  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int HOLD_LIMIT = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_CLIENTS-1:0]         request_i,
    output logic [N_CLIENTS-1:0]         grant_o,
    output logic [$clog2(N_CLIENTS)-1:0] owner_o,
    output logic                         busy_o,
    output logic                         hold_err_o,
    output logic [$clog2(N_CLIENTS)-1:0] err_client_o,
    input  logic                         err_clear_i
);
    localparam int IDX_W = $clog2(N_CLIENTS);

    arb_state_t           state_q, state_d;
    logic [N_CLIENTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [7:0]           hold_cnt_q, hold_cnt_d;
    logic [1:0]           gap_cnt_q, gap_cnt_d;
    logic                 busy_q;
    logic                 hold_err_q, hold_err_d;
    logic [IDX_W-1:0]     err_client_q, err_client_d;

    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [7:0]           hold_inc_s;
    logic                 new_err_s;

    rr_priority_picker #(
        .N_CLIENTS (N_CLIENTS)
    ) u_picker (
        .req_i   (request_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    // Saturating hold count; error fires on the edge that completes the
    // HOLD_LIMIT-th granted cycle, only if no error is already latched.
    always_comb begin
        hold_inc_s = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;
        new_err_s  = (state_q == GRANTED) && (HOLD_LIMIT != 0) &&
                     (hold_inc_s == 8'(HOLD_LIMIT)) && !hold_err_q;
    end

    // Arbiter FSM: next state, grant, owner, pointer and counters.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    grant_d    = N_CLIENTS'(1'b1) << pick_idx_s;
                    owner_d    = pick_idx_s;
                    hold_cnt_d = 8'd0;
                    state_d    = GRANTED;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANTED: begin
                hold_cnt_d = hold_inc_s;
                if (request_i[owner_q]) begin
                    state_d = GRANTED;
                end else begin
                    grant_d   = '0;
                    ptr_d     = (owner_q == IDX_W'(N_CLIENTS - 1)) ? IDX_W'(0)
                                                                   : owner_q + IDX_W'(1);
                    gap_cnt_d = 2'd0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == 2'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 2'd1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Sticky hold error; a new error outranks a simultaneous clear.
    always_comb begin
        hold_err_d   = hold_err_q;
        err_client_d = err_client_q;
        if (new_err_s) begin
            hold_err_d   = 1'b1;
            err_client_d = owner_q;
        end else if (err_clear_i) begin
            hold_err_d   = 1'b0;
            err_client_d = IDX_W'(0);
        end else begin
            hold_err_d   = hold_err_q;
        end
    end

    // State and output registers; reset drops grant immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= IDX_W'(0);
            ptr_q        <= IDX_W'(0);
            hold_cnt_q   <= 8'd0;
            gap_cnt_q    <= 2'd0;
            busy_q       <= 1'b0;
            hold_err_q   <= 1'b0;
            err_client_q <= IDX_W'(0);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            busy_q       <= |grant_d;
            hold_err_q   <= hold_err_d;
            err_client_q <= err_client_d;
        end
    end

    assign grant_o      = grant_q;
    assign owner_o      = owner_q;
    assign busy_o       = busy_q;
    assign hold_err_o   = hold_err_q;
    assign err_client_o = err_client_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
    localparam int N     = 4;
    localparam int GAP   = 1;
    localparam int HL    = 10;
    localparam int MAXH  = 4;
    localparam int BOUND = N * (MAXH + GAP + 1);

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic [3:0] request = 4'b0000;
    logic       err_clear = 1'b0;
    logic [3:0] grant_o;
    logic [1:0] owner_o;
    logic       busy_o;
    logic       hold_err_o;
    logic [1:0] err_client_o;

    mem_bus_arbiter #(
        .N_CLIENTS  (N),
        .GAP_CYCLES (GAP),
        .HOLD_LIMIT (HL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .request_i    (request),
        .grant_o      (grant_o),
        .owner_o      (owner_o),
        .busy_o       (busy_o),
        .hold_err_o   (hold_err_o),
        .err_client_o (err_client_o),
        .err_clear_i  (err_clear)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [3:0] g;
        logic [1:0] o;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         sb_on = 1'b1;
    bit         stress_on = 1'b0;
    logic [3:0] last_g = 4'b0000;
    int         wait_c[4];
    int         max_wait = 0;
    int         held[4];
    int         tgt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_g(input int dly, input logic [3:0] g, input logic [1:0] o);
        exp_t e;
        e.c = cyc + dly;
        e.g = g;
        e.o = o;
        sbq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one cycle before client w's grant edge; holds it for 'hold'
    // visible cycles, then releases and optionally re-requests.
    task automatic serve(input int w, input int hold, input bit rereq, input int nxt);
        tick(hold);
        request[w] = 1'b0;
        expect_g(1, 4'b0000, 2'd0);
        tick(1);
        if (rereq) request[w] = 1'b1;
        if (nxt >= 0) expect_g(2, 4'b0001 << nxt, 2'(nxt));
        tick(1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_grant"}, 32'(grant_o), 32'd0);
        check({tag, "_owner"}, 32'(owner_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_hold_err"}, 32'(hold_err_o), 32'd0);
        check({tag, "_err_client"}, 32'(err_client_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        request = 4'b0000;
        #1;
        check_reset_state("rst");
        tick(2);
        rst_ni = 1'b1;
        tick(1);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every grant change.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            n_cmp++;
            if (!($onehot0(grant_o) && (busy_o == (|grant_o)))) begin
                n_err++;
                $display("FAIL invariant: grant=%b busy=%b, required onehot0 and busy==|grant", grant_o, busy_o);
            end
            if (grant_o !== last_g) begin
                if (sb_on) begin
                    n_cmp++;
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: grant=%b at cyc %0d, required no change", grant_o, cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (cyc != e.c || grant_o !== e.g || (e.g != 4'b0000 && owner_o !== e.o)) begin
                            n_err++;
                            $display("FAIL sb_event: cyc=%0d grant=%b owner=%0d, expected cyc=%0d grant=%b owner=%0d",
                                     cyc, grant_o, owner_o, e.c, e.g, e.o);
                        end
                    end
                end
                last_g = grant_o;
            end
            if (stress_on) begin
                for (int i = 0; i < N; i++) begin
                    if (request[i] && !grant_o[i]) wait_c[i]++;
                    else wait_c[i] = 0;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            wait_c[i] = 0;
            held[i]   = 0;
            tgt[i]    = 1;
        end
        #2;
        do_reset();

        // Single client: grant one cycle after request, drop one after release.
        request = 4'b0001;
        expect_g(1, 4'b0001, 2'd0);
        tick(1);
        check("t1_busy", 32'(busy_o), 32'd1);
        serve(0, 4, 1'b0, -1);
        tick(2);
        do_reset();

        // All request, hold 3 each: order 0,1,2,3,0 with a gap between owners.
        request = 4'b1111;
        expect_g(1, 4'b0001, 2'd0);
        serve(0, 3, 1'b1, 1);
        serve(1, 3, 1'b1, 2);
        serve(2, 3, 1'b1, 3);
        serve(3, 3, 1'b1, 0);
        tick(3);
        request = 4'b0000;
        expect_g(1, 4'b0000, 2'd0);
        tick(3);

        // Move pointer to 2, then contention 1011: 3, then 0, then 1.
        request = 4'b0010;
        expect_g(1, 4'b0010, 2'd1);
        serve(1, 2, 1'b0, -1);
        request = 4'b1011;
        expect_g(1, 4'b1000, 2'd3);
        serve(3, 2, 1'b0, 0);
        serve(0, 2, 1'b0, 1);
        serve(1, 2, 1'b0, -1);

        // Hold error: client 1 holds 15 cycles; error after 10 held cycles.
        request = 4'b0010;
        expect_g(1, 4'b0010, 2'd1);
        tick(10);
        check("t4_no_err_yet", 32'(hold_err_o), 32'd0);
        err_clear = 1'b1;
        tick(1);
        check("t4_err_beats_clear", 32'(hold_err_o), 32'd1);
        check("t4_err_client", 32'(err_client_o), 32'd1);
        check("t4_grant_kept", 32'(grant_o), 32'h2);
        check("t4_busy", 32'(busy_o), 32'd1);
        err_clear = 1'b0;
        tick(1);
        check("t4_sticky", 32'(hold_err_o), 32'd1);
        err_clear = 1'b1;
        tick(1);
        check("t4_cleared", 32'(hold_err_o), 32'd0);
        check("t4_client_cleared", 32'(err_client_o), 32'd0);
        err_clear = 1'b0;
        tick(2);
        request = 4'b0000;
        expect_g(1, 4'b0000, 2'd0);
        tick(3);
        check("t4_no_reraise", 32'(hold_err_o), 32'd0);

        // Async reset mid-grant, then pointer restarts at 0.
        request = 4'b1000;
        expect_g(1, 4'b1000, 2'd3);
        tick(2);
        check("t5_owner_pre", 32'(owner_o), 32'd3);
        #3;
        rst_ni  = 1'b0;
        request = 4'b0000;
        expect_g(0, 4'b0000, 2'd0);
        #1;
        check_reset_state("t5_async");
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        request = 4'b0110;
        expect_g(1, 4'b0010, 2'd1);
        serve(1, 2, 1'b0, 2);
        serve(2, 2, 1'b0, -1);
        tick(2);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        // Random stress: invariants each cycle and bounded waiting.
        sb_on     = 1'b0;
        stress_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (grant_o[i]) begin
                    held[i]++;
                    if (held[i] >= tgt[i]) request[i] = 1'b0;
                end else begin
                    held[i] = 0;
                    if (!request[i] && $urandom_range(0, 2) == 0) begin
                        request[i] = 1'b1;
                        tgt[i]     = $urandom_range(1, MAXH);
                    end
                end
            end
            tick(1);
        end
        request = 4'b0000;
        tick(10);
        stress_on = 1'b0;
        n_cmp++;
        if (max_wait > BOUND) begin
            n_err++;
            $display("FAIL stress_wait: max wait %0d cycles, required <= %0d", max_wait, BOUND);
        end
        check("stress_no_hold_err", 32'(hold_err_o), 32'd0);
        check("stress_idle", 32'(grant_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
